cpu_control_fsm: RTL
====================

Name: cpu_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit CPU. It replaces the purely combinational control-word decoder with a registered sequencer: FETCH, EXEC, MEM and HALT.
- Drives the same control word into the datapath: PS, IR_L, AA/BA/DA, WR, Clr, FS, Cin, MuxD, MuxA, K, MemWrite, SS.
- Adds multi-cycle load/store with a memory-ready handshake, conditional branch, jump, halt, and a memory-wait timeout.

Parameters:
- W, 16, datapath/K width (>=16); K sign-extended to W.
- FS_W, 5, function-select width; IR[13:9] zero-extended to FS_W.
- TIMEOUT, 15, max wait cycles for mem_ready before bus error (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- IR  in  16  instruction register contents.
- mem_ready  in  1  memory handshake: access completes this cycle.
- cond  in  1  status bit selected by SS (datapath returns it combinationally).
- PS  out  2  PC op: 00 hold, 01 increment, 10 PC+K, 11 load R[AA].
- IR_L  out  1  IR load enable.
- AA, BA, DA  out  3 each  register addresses.
- WR  out  1  register-file write enable.
- Clr  out  1  datapath clear.
- FS  out  FS_W  ALU function.
- Cin  out  1  ALU carry-in.
- MuxD  out  5  one-hot D-bus select: 00001 mem, 00010 K, 00100 ALU, 01000 PC, 10000 status.
- MuxA  out  1  1 = PC onto A bus.
- K  out  W  constant.
- MemWrite  out  1  memory write strobe.
- SS  out  2  status select.
- state  out  2  FETCH=00, EXEC=01, MEM=10, HALT=11.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- IR fields: [15:14] class, [13:9] op, [8:6] DA, [5:3] AA, [2:0] BA. AA/BA/DA always equal these fields.
- Idle defaults: PS=00, IR_L=0, WR=0, Clr=0, MemWrite=0, MuxA=0, MuxD=00100, SS=IR[10:9], K=0, FS=IR[13:9], Cin=IR[9].
- Outputs are combinational from registered state plus IR and inputs.
- Reset (reset_n=0 at edge):
  - state<=FETCH, wait counter<=0, bus_err<=0.
  - While reset_n=0, outputs are forced combinationally to idle defaults with Clr=1.
  - Mid-access reset drops MemWrite the same cycle; the access is abandoned.
- FETCH:
  - IR_L=1.
  - If mem_ready: PS=01, next state EXEC, counter cleared.
  - Else counter increments; PS=00.
- EXEC, by class:
  - 00 ALU: WR=1, MuxD=00100. Next FETCH.
  - 01 LDI: K=sext(IR[5:0]), MuxD=00010, WR=1. Next FETCH.
  - 10 memory: no writes this cycle. Next MEM.
  - 11 control, by IR[13:12]:
    - 00 branch: K=sext(IR[8:0]); PS=10 if cond=1, else PS=00. Next FETCH.
    - 01 jump: PS=11. Next FETCH.
    - 10 halt: next HALT.
    - 11 NOP: next FETCH.
- MEM:
  - Load (IR[13]=0): MuxD=00001; WR=1 only in the cycle mem_ready=1.
  - Store (IR[13]=1): MemWrite=1 every MEM cycle until and including the mem_ready cycle.
  - On mem_ready: next FETCH, counter cleared.
- Timeout:
  - The wait counter counts consecutive non-ready cycles in FETCH/MEM.
  - When it reaches TIMEOUT with mem_ready still 0, bus_err<=1 and next state is HALT.
  - mem_ready in that same cycle wins: normal completion, no error.
- HALT: all idle defaults (PS=00); stays in HALT until reset. bus_err holds its value.
- Latency: ALU/LDI/branch/jump take 2 cycles with zero-wait memory; load/store take 3.
- PC increments exactly once per fetch, regardless of wait states.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants and class/control-opcode constants;
  - MuxD one-hot constants and PS codes;
  - function sext(value, from_width) to W.
- One natural sub-module: cpu_ctrl_timer, the wait counter plus timeout compare (inputs clear/count, output expired).

Test Plan:
- Reset then IR=16'h0A53 (ALU), mem_ready=1 -> FETCH: IR_L=1, PS=01; EXEC: WR=1, MuxD=00100, FS=00101, DA=1, AA=2, BA=3; back to FETCH.
- IR=16'h413F (LDI) -> EXEC: K=16'hFFFF, MuxD=00010, WR=1.
- Store IR=16'hA00A, mem_ready low 3 cycles in MEM -> MemWrite=1 for 4 cycles, WR=0 throughout; FETCH after the ready cycle.
- Branch IR=16'hC1FE, cond=1 then cond=0 on a second run -> K=16'hFFFE with PS=10; then PS=00.
- mem_ready held 0 in FETCH with TIMEOUT=15 -> bus_err=1 after 15 wait cycles, state=HALT, PS=00 persisting. reset_n low -> state=FETCH, bus_err=0.
- reset_n=0 during MEM store -> MemWrite=0 and Clr=1 that same cycle; state=FETCH after the edge.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control sequencer: states, instruction classes,
// control-word codes and the K sign-extension helper.
package cpu_ctrl_pkg;

  localparam int unsigned KMaxW = 64;

  localparam logic [1:0] StFetch = 2'b00;
  localparam logic [1:0] StExec  = 2'b01;
  localparam logic [1:0] StMem   = 2'b10;
  localparam logic [1:0] StHalt  = 2'b11;

  localparam logic [1:0] ClsAlu = 2'b00;
  localparam logic [1:0] ClsLdi = 2'b01;
  localparam logic [1:0] ClsMem = 2'b10;
  localparam logic [1:0] ClsCtl = 2'b11;

  localparam logic [1:0] CtlBranch = 2'b00;
  localparam logic [1:0] CtlJump   = 2'b01;
  localparam logic [1:0] CtlHalt   = 2'b10;
  localparam logic [1:0] CtlNop    = 2'b11;

  localparam logic [4:0] MuxDMem    = 5'b00001;
  localparam logic [4:0] MuxDK      = 5'b00010;
  localparam logic [4:0] MuxDAlu    = 5'b00100;
  localparam logic [4:0] MuxDPc     = 5'b01000;
  localparam logic [4:0] MuxDStatus = 5'b10000;

  localparam logic [1:0] PsHold = 2'b00;
  localparam logic [1:0] PsInc  = 2'b01;
  localparam logic [1:0] PsRel  = 2'b10;
  localparam logic [1:0] PsReg  = 2'b11;

  // Sign-extends the low from_width bits of value to KMaxW; callers slice down to W.
  function automatic logic [KMaxW-1:0] sext(input logic [KMaxW-1:0] value,
                                             input int unsigned from_width);
    int unsigned sh;
    logic signed [KMaxW-1:0] tmp;
    sh  = KMaxW - from_width;
    tmp = $signed(value << sh);
    return tmp >>> sh;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control-word bus between the sequencer (master) and the 16-bit datapath (slave).
interface cpu_control_fsm_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned FS_W = 5
);
  logic [15:0]     IR;
  logic            mem_ready;
  logic            cond;
  logic [1:0]      PS;
  logic            IR_L;
  logic [2:0]      AA;
  logic [2:0]      BA;
  logic [2:0]      DA;
  logic            WR;
  logic            Clr;
  logic [FS_W-1:0] FS;
  logic            Cin;
  logic [4:0]      MuxD;
  logic            MuxA;
  logic [W-1:0]    K;
  logic            MemWrite;
  logic [1:0]      SS;
  logic [1:0]      state;
  logic            bus_err;

  modport master (
    input  IR, mem_ready, cond,
    output PS, IR_L, AA, BA, DA, WR, Clr, FS, Cin, MuxD, MuxA, K, MemWrite, SS, state, bus_err
  );

  modport slave (
    output IR, mem_ready, cond,
    input  PS, IR_L, AA, BA, DA, WR, Clr, FS, Cin, MuxD, MuxA, K, MemWrite, SS, state, bus_err
  );
endinterface

// File: rtl/cpu_ctrl_timer.sv
// Counts consecutive memory-wait cycles; expired_o flags the wait that would reach Timeout.
module cpu_ctrl_timer #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);
  localparam int unsigned CntW = $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CntW'(Timeout))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Combinational so a same-cycle mem_ready (which asserts clear_i) always wins.
  assign expired_o = count_i && !clear_i && (cnt_q == CntW'(Timeout - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cpu_control_fsm.sv
// Registered FETCH/EXEC/MEM/HALT sequencer driving the datapath control word, with a
// memory-ready handshake, wait timeout and sticky bus error.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned FS_W    = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  cpu_control_fsm_if.master   bus_io
);
  logic [1:0] state_q, state_d;
  logic       bus_err_q, bus_err_d;
  logic       waiting, tmr_clear, tmr_expired;

  logic [1:0] cls, ctl;
  logic [KMaxW-1:0] k_ldi, k_br;

  logic [1:0]   ps;
  logic         ir_l, wr, clr, mem_write;
  logic [4:0]   muxd;
  logic [W-1:0] k;

  assign cls   = bus_io.IR[15:14];
  assign ctl   = bus_io.IR[13:12];
  assign k_ldi = sext({{(KMaxW-6){1'b0}}, bus_io.IR[5:0]}, 6);
  assign k_br  = sext({{(KMaxW-9){1'b0}}, bus_io.IR[8:0]}, 9);

  assign waiting   = ((state_q == StFetch) || (state_q == StMem)) && !bus_io.mem_ready;
  assign tmr_clear = !waiting;

  cpu_ctrl_timer #(
    .Timeout (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .clear_i   (tmr_clear),
    .count_i   (waiting),
    .expired_o (tmr_expired)
  );

  always_comb begin
    ps        = PsHold;
    ir_l      = 1'b0;
    wr        = 1'b0;
    clr       = 1'b0;
    mem_write = 1'b0;
    muxd      = MuxDAlu;
    k         = '0;
    state_d   = state_q;
    bus_err_d = bus_err_q;

    case (state_q)
      StFetch: begin
        ir_l = 1'b1;
        if (bus_io.mem_ready) begin
          ps      = PsInc;
          state_d = StExec;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExec: begin
        state_d = StFetch;
        unique case (cls)
          ClsAlu: wr = 1'b1;
          ClsLdi: begin
            k    = k_ldi[W-1:0];
            muxd = MuxDK;
            wr   = 1'b1;
          end
          ClsMem: state_d = StMem;
          ClsCtl: begin
            unique case (ctl)
              CtlBranch: begin
                k  = k_br[W-1:0];
                ps = bus_io.cond ? PsRel : PsHold;
              end
              CtlJump:  ps = PsReg;
              CtlHalt:  state_d = StHalt;
              CtlNop:   state_d = StFetch;
            endcase
          end
        endcase
      end
      StMem: begin
        if (!bus_io.IR[13]) begin
          muxd = MuxDMem;
          wr   = bus_io.mem_ready;
        end else begin
          mem_write = 1'b1;
        end
        if (bus_io.mem_ready) begin
          state_d = StFetch;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end
      end
      default: state_d = StHalt;
    endcase

    // Reset abandons any access in the same cycle, before the clock edge.
    if (!reset_n) begin
      ps        = PsHold;
      ir_l      = 1'b0;
      wr        = 1'b0;
      clr       = 1'b1;
      mem_write = 1'b0;
      muxd      = MuxDAlu;
      k         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_io.PS       = ps;
  assign bus_io.IR_L     = ir_l;
  assign bus_io.AA       = bus_io.IR[5:3];
  assign bus_io.BA       = bus_io.IR[2:0];
  assign bus_io.DA       = bus_io.IR[8:6];
  assign bus_io.WR       = wr;
  assign bus_io.Clr      = clr;
  assign bus_io.FS       = FS_W'(bus_io.IR[13:9]);
  assign bus_io.Cin      = bus_io.IR[9];
  assign bus_io.MuxD     = muxd;
  assign bus_io.MuxA     = 1'b0;
  assign bus_io.K        = k;
  assign bus_io.MemWrite = mem_write;
  assign bus_io.SS       = bus_io.IR[10:9];
  assign bus_io.state    = state_q;
  assign bus_io.bus_err  = bus_err_q;
endmodule
